// File: rtl/vadd_arbiter.sv
// Two-requester arbiter in front of a shared fixed-latency add/min/max unit.
// Round-robin grants, burst locking, and a tag line that routes each result back to its requester.
module vadd_arbiter #(
  parameter int REQ_DATA_WIDTH = 64,
  parameter int SEW_WIDTH      = 2,
  parameter int OPSEL_WIDTH    = 9,
  parameter int LATENCY        = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      req0_valid,
  output logic                      req0_ready,
  input  logic [REQ_DATA_WIDTH-1:0] req0_vec0,
  input  logic [REQ_DATA_WIDTH-1:0] req0_vec1,
  input  logic [SEW_WIDTH-1:0]      req0_sew,
  input  logic [OPSEL_WIDTH-1:0]    req0_opSel,
  input  logic                      req0_last,
  input  logic                      req1_valid,
  output logic                      req1_ready,
  input  logic [REQ_DATA_WIDTH-1:0] req1_vec0,
  input  logic [REQ_DATA_WIDTH-1:0] req1_vec1,
  input  logic [SEW_WIDTH-1:0]      req1_sew,
  input  logic [OPSEL_WIDTH-1:0]    req1_opSel,
  input  logic                      req1_last,
  output logic                      alu_valid,
  output logic [REQ_DATA_WIDTH-1:0] alu_vec0,
  output logic [REQ_DATA_WIDTH-1:0] alu_vec1,
  output logic [SEW_WIDTH-1:0]      alu_sew,
  output logic [OPSEL_WIDTH-1:0]    alu_opSel,
  input  logic                      alu_out_valid,
  input  logic [REQ_DATA_WIDTH-1:0] alu_out_vec,
  output logic                      resp0_valid,
  output logic [REQ_DATA_WIDTH-1:0] resp0_vec,
  output logic                      resp1_valid,
  output logic [REQ_DATA_WIDTH-1:0] resp1_vec,
  output logic                      busy,
  output logic                      err
);

  typedef enum logic [1:0] {IDLE, LOCK0, LOCK1} state_t;

  state_t                    state_q, state_d;
  logic                      last_q, last_d;
  logic                      alu_valid_q, alu_valid_d;
  logic                      alu_id_q, alu_id_d;
  logic [REQ_DATA_WIDTH-1:0] alu_vec0_q, alu_vec0_d;
  logic [REQ_DATA_WIDTH-1:0] alu_vec1_q, alu_vec1_d;
  logic [SEW_WIDTH-1:0]      alu_sew_q, alu_sew_d;
  logic [OPSEL_WIDTH-1:0]    alu_opsel_q, alu_opsel_d;
  logic [LATENCY-1:0]        tag_v_q, tag_v_d;
  logic [LATENCY-1:0]        tag_id_q, tag_id_d;
  logic                      resp0_valid_q, resp0_valid_d;
  logic                      resp1_valid_q, resp1_valid_d;
  logic [REQ_DATA_WIDTH-1:0] resp0_vec_q, resp0_vec_d;
  logic [REQ_DATA_WIDTH-1:0] resp1_vec_q, resp1_vec_d;
  logic                      err_q, err_d;

  logic accept, acc_id, acc_last, tag_out_v, tag_out_id, hit;

  // Grant logic; a tie in IDLE goes to whoever was not served last.
  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    if (!rst) begin
      case (state_q)
        IDLE: begin
          if (req0_valid && req1_valid) begin
            req0_ready = last_q;
            req1_ready = !last_q;
          end else begin
            req0_ready = req0_valid;
            req1_ready = req1_valid;
          end
        end
        LOCK0:   req0_ready = req0_valid;
        LOCK1:   req1_ready = req1_valid;
        default: ;
      endcase
    end
  end

  assign accept     = req0_ready | req1_ready;
  assign acc_id     = req1_ready;
  assign acc_last   = acc_id ? req1_last : req0_last;
  assign tag_out_v  = tag_v_q[LATENCY-1];
  assign tag_out_id = tag_id_q[LATENCY-1];
  assign hit        = alu_out_valid && tag_out_v;

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    if (accept) begin
      last_d = acc_id;
      if (acc_last)    state_d = IDLE;
      else if (acc_id) state_d = LOCK1;
      else             state_d = LOCK0;
    end

    alu_valid_d = accept;
    alu_id_d    = acc_id;
    alu_vec0_d  = '0;
    alu_vec1_d  = '0;
    alu_sew_d   = '0;
    alu_opsel_d = '0;
    if (accept) begin
      alu_vec0_d  = acc_id ? req1_vec0  : req0_vec0;
      alu_vec1_d  = acc_id ? req1_vec1  : req0_vec1;
      alu_sew_d   = acc_id ? req1_sew   : req0_sew;
      alu_opsel_d = acc_id ? req1_opSel : req0_opSel;
    end

    // Tag line enters on the issue cycle so its tail meets the result cycle.
    tag_v_d  = (tag_v_q << 1)  | LATENCY'(alu_valid_q);
    tag_id_d = (tag_id_q << 1) | LATENCY'(alu_id_q);

    resp0_valid_d = hit && !tag_out_id;
    resp1_valid_d = hit && tag_out_id;
    resp0_vec_d   = resp0_valid_d ? alu_out_vec : '0;
    resp1_vec_d   = resp1_valid_d ? alu_out_vec : '0;
    err_d         = err_q | (alu_out_valid ^ tag_out_v);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      last_q        <= 1'b1;
      alu_valid_q   <= 1'b0;
      alu_id_q      <= 1'b0;
      alu_vec0_q    <= '0;
      alu_vec1_q    <= '0;
      alu_sew_q     <= '0;
      alu_opsel_q   <= '0;
      tag_v_q       <= '0;
      tag_id_q      <= '0;
      resp0_valid_q <= 1'b0;
      resp1_valid_q <= 1'b0;
      resp0_vec_q   <= '0;
      resp1_vec_q   <= '0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      last_q        <= last_d;
      alu_valid_q   <= alu_valid_d;
      alu_id_q      <= alu_id_d;
      alu_vec0_q    <= alu_vec0_d;
      alu_vec1_q    <= alu_vec1_d;
      alu_sew_q     <= alu_sew_d;
      alu_opsel_q   <= alu_opsel_d;
      tag_v_q       <= tag_v_d;
      tag_id_q      <= tag_id_d;
      resp0_valid_q <= resp0_valid_d;
      resp1_valid_q <= resp1_valid_d;
      resp0_vec_q   <= resp0_vec_d;
      resp1_vec_q   <= resp1_vec_d;
      err_q         <= err_d;
    end
  end

  assign alu_valid   = alu_valid_q;
  assign alu_vec0    = alu_vec0_q;
  assign alu_vec1    = alu_vec1_q;
  assign alu_sew     = alu_sew_q;
  assign alu_opSel   = alu_opsel_q;
  assign resp0_valid = resp0_valid_q;
  assign resp1_valid = resp1_valid_q;
  assign resp0_vec   = resp0_vec_q;
  assign resp1_vec   = resp1_vec_q;
  assign err         = err_q;
  assign busy        = (state_q != IDLE) | (|tag_v_q) | alu_valid_q | resp0_valid_q | resp1_valid_q;

endmodule

// File: tb/tb_vadd_arbiter.sv
// Scoreboard bench for vadd_arbiter with a behavioural model of the shared add/min/max unit.
// Stimulus pushes hand-computed results; a negedge monitor pops them as responses appear.
module tb_vadd_arbiter;
  localparam int W   = 64;
  localparam int LAT = 4;

  logic          clk;
  logic          rst;
  logic          req0_valid, req0_ready, req0_last;
  logic [W-1:0]  req0_vec0, req0_vec1;
  logic [1:0]    req0_sew;
  logic [8:0]    req0_opSel;
  logic          req1_valid, req1_ready, req1_last;
  logic [W-1:0]  req1_vec0, req1_vec1;
  logic [1:0]    req1_sew;
  logic [8:0]    req1_opSel;
  logic          alu_valid;
  logic [W-1:0]  alu_vec0, alu_vec1;
  logic [1:0]    alu_sew;
  logic [8:0]    alu_opSel;
  logic          alu_out_valid;
  logic [W-1:0]  alu_out_vec;
  logic          resp0_valid, resp1_valid;
  logic [W-1:0]  resp0_vec, resp1_vec;
  logic          busy, err;

  logic          force_out;
  logic [LAT-1:0] mdl_v;
  logic [W-1:0]  mdl_d [LAT];

  typedef struct {
    int           id;
    logic [W-1:0] data;
    int           cyc;
  } exp_t;

  exp_t exp_q[$];
  exp_t exp_e;
  int   cyc;
  int   n_checks;
  int   n_errors;
  int   c0;

  vadd_arbiter #(.REQ_DATA_WIDTH(W), .SEW_WIDTH(2), .OPSEL_WIDTH(9), .LATENCY(LAT)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_vec0(req0_vec0), .req0_vec1(req0_vec1),
    .req0_sew(req0_sew), .req0_opSel(req0_opSel), .req0_last(req0_last),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_vec0(req1_vec0), .req1_vec1(req1_vec1),
    .req1_sew(req1_sew), .req1_opSel(req1_opSel), .req1_last(req1_last),
    .alu_valid(alu_valid), .alu_vec0(alu_vec0), .alu_vec1(alu_vec1), .alu_sew(alu_sew),
    .alu_opSel(alu_opSel), .alu_out_valid(alu_out_valid), .alu_out_vec(alu_out_vec),
    .resp0_valid(resp0_valid), .resp0_vec(resp0_vec), .resp1_valid(resp1_valid), .resp1_vec(resp1_vec),
    .busy(busy), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [W-1:0] aluCompute(input logic [W-1:0] a, input logic [W-1:0] b,
                                              input logic [8:0] op);
    case (op)
      9'd1:    return (a < b) ? a : b;
      9'd2:    return (a > b) ? a : b;
      default: return a + b;
    endcase
  endfunction

  // Shared unit model: fixed latency, reset together with the arbiter.
  always @(posedge clk) begin
    if (rst) begin
      mdl_v <= '0;
    end else begin
      mdl_v    <= {mdl_v[LAT-2:0], alu_valid};
      mdl_d[0] <= aluCompute(alu_vec0, alu_vec1, alu_opSel);
      for (int i = 1; i < LAT; i++) mdl_d[i] <= mdl_d[i-1];
    end
  end

  assign alu_out_valid = mdl_v[LAT-1] | force_out;
  assign alu_out_vec   = mdl_d[LAT-1];

  task automatic checkOutput(input string name, input logic [W-1:0] act, input logic [W-1:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, expv, cyc);
    end
  endtask

  task automatic applyStimulus(input int id, input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic [8:0] op, input logic last);
    if (id == 0) begin
      req0_valid = v; req0_vec0 = a; req0_vec1 = b; req0_opSel = op; req0_last = last; req0_sew = 2'd3;
    end else begin
      req1_valid = v; req1_vec0 = a; req1_vec1 = b; req1_opSel = op; req1_last = last; req1_sew = 2'd3;
    end
  endtask

  task automatic pushExp(input int id, input logic [W-1:0] data);
    exp_t e;
    e.id   = id;
    e.data = data;
    e.cyc  = cyc + LAT + 2;
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name);
    repeat (LAT + 4) tick();
    checkOutput(name, 64'(exp_q.size()), 64'd0);
  endtask

  task automatic doReset();
    rst = 1'b1;
    applyStimulus(0, 1'b0, '0, '0, '0, 1'b0);
    applyStimulus(1, 1'b0, '0, '0, '0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("rst_ready", 64'({req0_ready, req1_ready}), 64'd0);
    checkOutput("rst_alu_valid", 64'(alu_valid), 64'd0);
    checkOutput("rst_resp", 64'({resp0_valid, resp1_valid}), 64'd0);
    checkOutput("rst_busy", 64'(busy), 64'd0);
    checkOutput("rst_err", 64'(err), 64'd0);
  endtask

  // Monitor: pops the scoreboard on every response and polices idle-zero rules.
  always @(negedge clk) begin
    if (!rst && (resp0_valid || resp1_valid)) begin
      if (resp0_valid && resp1_valid) begin
        n_checks++; n_errors++;
        $display("[TB] FAIL dual_resp: got both resp valids, expected one at cycle %0d", cyc);
      end
      if (exp_q.size() == 0) begin
        n_checks++; n_errors++;
        $display("[TB] FAIL unexpected_resp: got resp0=%0b resp1=%0b expected none at cycle %0d",
                 resp0_valid, resp1_valid, cyc);
      end else begin
        exp_e = exp_q.pop_front();
        checkOutput("resp_id", 64'(resp1_valid), 64'(exp_e.id));
        checkOutput("resp_data", resp1_valid ? resp1_vec : resp0_vec, exp_e.data);
        checkOutput("resp_cycle", 64'(cyc), 64'(exp_e.cyc));
      end
    end
    if (!alu_valid)
      checkOutput("alu_idle_zero", 64'(|{alu_vec0, alu_vec1, alu_sew, alu_opSel}), 64'd0);
    if (!resp0_valid) checkOutput("resp0_idle_zero", resp0_vec, 64'd0);
    if (!resp1_valid) checkOutput("resp1_idle_zero", resp1_vec, 64'd0);
    checkOutput("ready_no_valid", 64'((req0_ready & !req0_valid) | (req1_ready & !req1_valid)), 64'd0);
  end

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    force_out = 1'b0;
    rst       = 1'b1;

    // Single beat
    doReset();
    tick();
    applyStimulus(0, 1'b1, 64'h05, 64'h03, 9'd0, 1'b1);
    pushExp(0, 64'h08);
    @(negedge clk);
    checkOutput("t1_ready0", 64'(req0_ready), 64'd1);
    checkOutput("t1_alu_valid_c0", 64'(alu_valid), 64'd0);
    tick();
    applyStimulus(0, 1'b0, '0, '0, '0, 1'b0);
    @(negedge clk);
    checkOutput("t1_alu_valid_c1", 64'(alu_valid), 64'd1);
    checkOutput("t1_alu_vec0", alu_vec0, 64'h05);
    checkOutput("t1_alu_vec1", alu_vec1, 64'h03);
    checkOutput("t1_busy", 64'(busy), 64'd1);
    drain("t1_drain");

    // Tie: alternating grants starting with requester 0
    doReset();
    for (int k = 0; k < 4; k++) begin
      tick();
      applyStimulus(0, 1'b1, (k < 2) ? 64'h10 : 64'h20, 64'h1, 9'd0, 1'b1);
      applyStimulus(1, 1'b1, (k < 2) ? 64'h30 : 64'h40, 64'h2, 9'd0, 1'b1);
      if (k == 0) pushExp(0, 64'h11);
      if (k == 1) pushExp(1, 64'h32);
      if (k == 2) pushExp(0, 64'h21);
      if (k == 3) pushExp(1, 64'h42);
      @(negedge clk);
      checkOutput("tie_ready0", 64'(req0_ready), 64'(k % 2 == 0));
      checkOutput("tie_ready1", 64'(req1_ready), 64'(k % 2 == 1));
    end
    tick();
    applyStimulus(0, 1'b0, '0, '0, '0, 1'b0);
    applyStimulus(1, 1'b0, '0, '0, '0, 1'b0);
    drain("tie_drain");

    // Lock: req1 burst with a two-cycle bubble while req0 waits
    doReset();
    tick();
    applyStimulus(1, 1'b1, 64'h100, 64'h1, 9'd0, 1'b0);
    pushExp(1, 64'h101);
    @(negedge clk);
    checkOutput("lock_k0_ready1", 64'(req1_ready), 64'd1);
    tick();
    applyStimulus(1, 1'b0, '0, '0, '0, 1'b0);
    applyStimulus(0, 1'b1, 64'h50, 64'h60, 9'd2, 1'b1);
    @(negedge clk);
    checkOutput("lock_k1_ready0", 64'(req0_ready), 64'd0);
    checkOutput("lock_k1_alu_valid", 64'(alu_valid), 64'd1);
    tick();
    @(negedge clk);
    checkOutput("lock_k2_ready0", 64'(req0_ready), 64'd0);
    checkOutput("lock_k2_alu_valid", 64'(alu_valid), 64'd0);
    checkOutput("lock_k2_busy", 64'(busy), 64'd1);
    tick();
    applyStimulus(1, 1'b1, 64'h200, 64'h2, 9'd0, 1'b0);
    pushExp(1, 64'h202);
    @(negedge clk);
    checkOutput("lock_k3_ready1", 64'(req1_ready), 64'd1);
    checkOutput("lock_k3_ready0", 64'(req0_ready), 64'd0);
    checkOutput("lock_k3_alu_valid", 64'(alu_valid), 64'd0);
    tick();
    applyStimulus(1, 1'b1, 64'h300, 64'h3, 9'd1, 1'b1);
    pushExp(1, 64'h3);
    @(negedge clk);
    checkOutput("lock_k4_ready1", 64'(req1_ready), 64'd1);
    checkOutput("lock_k4_ready0", 64'(req0_ready), 64'd0);
    checkOutput("lock_k4_alu_valid", 64'(alu_valid), 64'd1);
    tick();
    applyStimulus(1, 1'b0, '0, '0, '0, 1'b0);
    pushExp(0, 64'h60);
    @(negedge clk);
    checkOutput("lock_k5_ready0", 64'(req0_ready), 64'd1);
    checkOutput("lock_k5_alu_valid", 64'(alu_valid), 64'd1);
    tick();
    applyStimulus(0, 1'b0, '0, '0, '0, 1'b0);
    @(negedge clk);
    checkOutput("lock_k6_alu_valid", 64'(alu_valid), 64'd1);
    drain("lock_drain");

    // Misalignment: result strobe with an empty tag line
    doReset();
    tick();
    force_out = 1'b1;
    @(negedge clk);
    checkOutput("mis_err_before", 64'(err), 64'd0);
    tick();
    force_out = 1'b0;
    @(negedge clk);
    checkOutput("mis_err_set", 64'(err), 64'd1);
    checkOutput("mis_no_resp", 64'({resp0_valid, resp1_valid}), 64'd0);
    repeat (3) tick();
    @(negedge clk);
    checkOutput("mis_err_sticky", 64'(err), 64'd1);
    checkOutput("mis_busy", 64'(busy), 64'd0);

    // Reset with beats in flight
    doReset();
    for (int k = 0; k < 3; k++) begin
      tick();
      applyStimulus(0, 1'b1, 64'(k + 1), 64'h7, 9'd0, 1'b1);
    end
    tick();
    applyStimulus(0, 1'b0, '0, '0, '0, 1'b0);
    tick();
    @(negedge clk);
    checkOutput("rif_busy_before", 64'(busy), 64'd1);
    doReset();
    repeat (10) tick();
    @(negedge clk);
    checkOutput("rif_err_after", 64'(err), 64'd0);
    checkOutput("rif_busy_after", 64'(busy), 64'd0);

    // Stream: 20 back-to-back beats from requester 0
    doReset();
    c0 = 0;
    for (int i = 0; i < 20; i++) begin
      logic [W-1:0] a, b, e;
      a = 64'(i) * 64'h100 + 64'h7;
      b = 64'(i);
      e = (i % 3 == 0) ? a + b : (i % 3 == 1) ? b : a;
      tick();
      if (i == 0) c0 = cyc;
      applyStimulus(0, 1'b1, a, b, 9'(i % 3), 1'b1);
      pushExp(0, e);
      @(negedge clk);
      checkOutput("stream_ready0", 64'(req0_ready), 64'd1);
      if (i > 0) checkOutput("stream_alu_valid", 64'(alu_valid), 64'd1);
    end
    tick();
    applyStimulus(0, 1'b0, '0, '0, '0, 1'b0);
    @(negedge clk);
    checkOutput("stream_alu_valid_tail", 64'(alu_valid), 64'd1);
    checkOutput("stream_span", 64'(cyc - c0), 64'd20);
    drain("stream_drain");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/vadd_arbiter.md
VADD_ARBITER -- requirements
Module: vadd_arbiter

Interface
REQ-001 Parameters (name, default, meaning):
- REQ_DATA_WIDTH, 64, operand and result width.
- SEW_WIDTH, 2, element-width code width.
- OPSEL_WIDTH, 9, opcode-select width.
- LATENCY, 4, cycles from alu_valid to alu_out_valid of the shared add/min/max unit.

REQ-002 Ports (name, direction, width, meaning); N = 0,1, one port per requester:
- clk, in, 1, single clock.
- rst, in, 1, reset; synchronous, active-high.
- reqN_valid, in, 1, requester N beat valid.
- reqN_ready, out, 1, requester N beat accepted this cycle.
- reqN_vec0, in, REQ_DATA_WIDTH, operand 0.
- reqN_vec1, in, REQ_DATA_WIDTH, operand 1.
- reqN_sew, in, SEW_WIDTH, element width.
- reqN_opSel, in, OPSEL_WIDTH, operation select.
- reqN_last, in, 1, final beat of a burst.
- alu_valid, out, 1, issue strobe to the shared unit.
- alu_vec0, out, REQ_DATA_WIDTH, issued operand 0.
- alu_vec1, out, REQ_DATA_WIDTH, issued operand 1.
- alu_sew, out, SEW_WIDTH, issued element width.
- alu_opSel, out, OPSEL_WIDTH, issued operation.
- alu_out_valid, in, 1, result valid from the unit.
- alu_out_vec, in, REQ_DATA_WIDTH, result from the unit.
- respN_valid, out, 1, result for requester N.
- respN_vec, out, REQ_DATA_WIDTH, result data.
- busy, out, 1, burst locked or any beat in flight.
- err, out, 1, sticky tag/result misalignment.

Function
REQ-003 The block shall accept at most one beat per cycle; a beat is accepted when reqN_valid and reqN_ready are both high. The shared unit never backpressures.
REQ-004 FSM states IDLE, LOCK0, LOCK1:
- IDLE: accepted beat from N with last=0 -> LOCKN; with last=1 -> stay IDLE.
- LOCKN: only reqN_ready may be high (equal to reqN_valid); accepted beat with last=1 -> IDLE.
- LOCKN with reqN_valid low holds LOCKN and issues nothing (bubble); the other requester is blocked.
REQ-005 Arbitration in IDLE is round-robin:
- Single valid requester: granted.
- Both valid: grant the requester not recorded as last served.
- The last-served pointer updates on every accepted beat and resets to 1, so requester 0 wins the first tie.
REQ-006 reqN_ready shall be combinational from state, pointer and reqN_valid; reqN_ready is never high while reqN_valid is low.
REQ-007 alu_* outputs shall be registered. An accepted beat appears on alu_* with alu_valid=1 exactly one cycle later. When alu_valid=0, alu_vec0, alu_vec1, alu_sew and alu_opSel are all zero.
REQ-008 Each issue shall push {valid, id} into a LATENCY-deep tag shift line aligned to alu_valid; the tag-line output coincides with the cycle alu_out_valid is due.
REQ-009 On alu_out_valid with a valid tag of id N:
- respN_valid=1 and respN_vec=alu_out_vec, registered, one cycle later.
- The other requester's resp_valid=0; respN_vec is zero when not valid.
- Total latency from accept to resp = LATENCY+2 cycles (6 at default).
REQ-010 Misalignment (alu_out_valid without a valid tag, or a valid tag without alu_out_valid) shall set err, held until rst; the result is dropped and no resp is asserted.
REQ-011 busy = (state != IDLE) OR (any tag-line stage valid) OR (alu_valid) OR (any resp pending in its output register).
REQ-012 Full throughput: back-to-back beats from either requester every cycle, with no bubbles except LOCK stalls.

Reset
REQ-013 rst shall drive, on the next clock edge:
- FSM to IDLE, pointer to 1, tag line cleared.
- All outputs to 0: reqN_ready, alu_*, respN_*, busy, err.
REQ-014 rst mid-burst or with beats in flight shall discard them with no resp. The shared unit is reset by the same rst, so no stale alu_out_valid arrives and err stays 0.

Verification
REQ-015 Single beat: req0 valid, last=1, vec0=0x05, vec1=0x03, opSel=add, at cycle 0 -> req0_ready=1 at cycle 0; alu_valid at cycle 1; resp0_valid=1 at cycle 6.
REQ-016 Tie: both valid with last=1 for 4 cycles after reset -> grants 0,1,0,1; resp ids follow in the same order, one per cycle.
REQ-017 Lock: req1 sends 3 beats (last on beat 3) while req0 is continuously valid; req1 drops valid for 2 cycles mid-burst -> req0_ready stays 0 until the cycle after req1's last beat; alu_valid shows a 2-cycle gap.
REQ-018 Misalignment: force alu_out_valid=1 with an empty tag line -> err=1 on the next cycle and persists; no resp asserted.
REQ-019 Reset in flight: 3 beats accepted, rst asserted 2 cycles later -> no respN_valid afterwards; busy=0 and err=0 after reset.
REQ-020 Stream: req0 valid with last=1 every cycle for 20 cycles -> 20 consecutive resp0_valid pulses with data in order; alu_valid has no gaps.
